// File: rtl/imem_load_arbiter.sv
// Single-port instruction memory owner shared by the program loader (boot) and IF fetch (run).
// Latency: grant, read data and write enable are combinational (zero cycles); phase changes take effect next cycle.
// Backpressure: loader sees ld_ready=0 while fetch owns the port; fetch sees fetch_gnt=0 (cpu_stall=1) in boot or on a forced loader write.
// Optional feature: define IMEM_ARB_RUNTIME_LOAD_EN to allow loader writes in RUN with bounded-wait fairness.
module imem_load_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic              reload,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_gnt,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              cpu_stall,
   output logic              boot_done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // The wait counter is 4 bits wide, so the fairness bound must fit in it.
   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("imem_load_arbiter: MAX_WAIT must be in 1..15");
   end

   typedef enum logic {BOOT, RUN} state_t;

   localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t state, state_nxt;
   logic   ld_ok;
   logic   fetch_ok;
   logic   ld_acc;

`ifdef IMEM_ARB_RUNTIME_LOAD_EN
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   logic [3:0] wait_cnt, wait_cnt_nxt;
`endif

   // Word-aligned and inside the memory: low two bits zero, nothing above the index field.
   always_comb begin
      ld_ok    = (ld_addr[1:0] == 2'b00) && (ld_addr[31:ADDR_W+2] == '0);
      fetch_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:ADDR_W+2] == '0);
   end

   // Phase register (and loader wait counter when runtime loading is built in).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
         wait_cnt <= '0;
`endif
      end else begin
         state <= state_nxt;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
         wait_cnt <= wait_cnt_nxt;
`endif
      end
   end

   // Port arbitration and next phase; fetch wins in RUN unless the loader has waited MAX_WAIT cycles.
   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      fetch_gnt = 1'b0;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
      wait_cnt_nxt = '0;
`endif
      if (state == BOOT) begin
         ld_ready = 1'b1;
         // A final-word write beats a same-cycle reload pulse, which BOOT ignores anyway.
         if (ld_valid && ld_last) begin
            state_nxt = RUN;
         end
      end else begin
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
         if (!fetch_req) begin
            ld_ready = 1'b1;
         end else if (wait_cnt == MAX_WAIT_C) begin
            ld_ready = 1'b1;
         end else begin
            fetch_gnt = 1'b1;
         end
         // A blocked request can only happen with wait_cnt below the bound, so no overflow.
         if (ld_valid && !ld_ready) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
         end
`else
         fetch_gnt = fetch_req;
`endif
         if (reload) begin
            state_nxt = BOOT;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
            wait_cnt_nxt = '0;
`endif
         end
      end
      // No write may be accepted while reset is held.
      if (rst) begin
         ld_ready = 1'b0;
      end
   end

   // Memory port drive: fetch address when granted, loader address otherwise; bad writes are dropped.
   always_comb begin
      ld_acc      = ld_valid && ld_ready;
      mem_we      = ld_acc && ld_ok;
      mem_wdata   = ld_data;
      mem_addr    = fetch_gnt ? fetch_addr[ADDR_W+1:2] : ld_addr[ADDR_W+1:2];
      fetch_rdata = (fetch_gnt && fetch_ok) ? mem_rdata : '0;
      cpu_stall   = (state == BOOT) || (fetch_req && !fetch_gnt);
      boot_done   = (state == RUN);
   end

   // Count of good loader writes since the last boot entry, saturating at the memory depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_loaded <= '0;
      end else if (state == RUN && reload) begin
         words_loaded <= '0;
      end else if (mem_we && words_loaded != WORDS_MAX) begin
         words_loaded <= words_loaded + 1'b1;
      end
   end

   // Sticky flag for any accepted write or granted fetch carrying a bad address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if ((ld_acc && !ld_ok) || (fetch_gnt && !fetch_ok)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: directed vector table, hand-written corner sequences, random traffic.
// All expected values come from constants or a phase/queue-level model of the arbitration rules.
// The bench owns a 32-word memory array attached to the DUT memory port.
module tb_imem_load_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MW = 4;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
   localparam bit RT = 1'b1;
`else
   localparam bit RT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_valid, ld_ready, ld_last, reload;
   logic [31:0]   ld_addr, fetch_addr;
   logic [DW-1:0] ld_data, fetch_rdata, mem_wdata, mem_rdata;
   logic          fetch_req, fetch_gnt, cpu_stall, boot_done, err, mem_we;
   logic [AW:0]   words_loaded;
   logic [AW-1:0] mem_addr;

   imem_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_last(ld_last), .reload(reload),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rdata(fetch_rdata), .cpu_stall(cpu_stall), .boot_done(boot_done), .err(err),
      .words_loaded(words_loaded), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Instruction memory array on the DUT port.
   logic [DW-1:0] ram [32] = '{default: '0};
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

   int vectors = 0;
   int errors  = 0;

   // Reference model: phase flag, blocked-cycle count, counters, expected memory image.
   bit          m_run;
   int          m_wait;
   int          m_words;
   bit          m_err;
   logic [31:0] m_mem [32];
   bit          e_ready, e_gnt, e_stall, e_we;
   logic [31:0] e_rdata;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a % 4 == 0) && (a < 32'd128);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      bool_forced: begin end
      e_gnt   = m_run && fetch_req && !(RT && m_wait == MW);
      e_ready = !m_run || (RT && (!fetch_req || m_wait == MW));
      e_we    = ld_valid && e_ready && addr_ok(ld_addr);
      e_rdata = (e_gnt && addr_ok(fetch_addr)) ? m_mem[fetch_addr / 4] : 32'h0;
      e_stall = !m_run || (fetch_req && !e_gnt);
   endtask

   task automatic model_adv();
      bit acc;
      acc = ld_valid && e_ready;
      if (acc && addr_ok(ld_addr)) begin
         m_mem[ld_addr / 4] = ld_data;
         if (m_words < 32) m_words++;
      end
      if ((acc && !addr_ok(ld_addr)) || (e_gnt && !addr_ok(fetch_addr))) m_err = 1'b1;
      if (m_run) begin
         if (reload) begin
            m_run = 1'b0; m_words = 0; m_wait = 0;
         end else if (!ld_valid || acc) begin
            m_wait = 0;
         end else begin
            m_wait++;
         end
      end else if (acc && ld_last) begin
         m_run = 1'b1;
      end
   endtask

   task automatic check_all();
      model_eval();
      check("ld_ready", 64'(ld_ready), 64'(e_ready));
      check("fetch_gnt", 64'(fetch_gnt), 64'(e_gnt));
      check("fetch_rdata", 64'(fetch_rdata), 64'(e_rdata));
      check("cpu_stall", 64'(cpu_stall), 64'(e_stall));
      check("boot_done", 64'(boot_done), 64'(m_run));
      check("err", 64'(err), 64'(m_err));
      check("words_loaded", 64'(words_loaded), 64'(m_words));
      check("mem_we", 64'(mem_we), 64'(e_we));
      if (e_we) begin
         check("mem_addr", 64'(mem_addr), 64'(ld_addr / 4));
         check("mem_wdata", 64'(mem_wdata), 64'(ld_data));
      end
   endtask

   // One clock: entered just after a falling edge with inputs already driven.
   task automatic cycle();
      #2;
      check_all();
      @(posedge clk);
      model_adv();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ld_valid = 0; ld_addr = 0; ld_data = 0; ld_last = 0; reload = 0;
      fetch_req = 0; fetch_addr = 0;
   endtask

   // Assert reset asynchronously, check reset values, release on the next falling edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_run = 0; m_wait = 0; m_words = 0; m_err = 0;
      check("rst ld_ready", 64'(ld_ready), 64'h0);
      check("rst fetch_gnt", 64'(fetch_gnt), 64'h0);
      check("rst fetch_rdata", 64'(fetch_rdata), 64'h0);
      check("rst cpu_stall", 64'(cpu_stall), 64'h1);
      check("rst boot_done", 64'(boot_done), 64'h0);
      check("rst err", 64'(err), 64'h0);
      check("rst words_loaded", 64'(words_loaded), 64'h0);
      check("rst mem_we", 64'(mem_we), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
   endtask

   typedef struct {
      logic        vld;
      logic [31:0] la;
      logic [31:0] ld;
      logic        last;
      logic        rel;
      logic        freq;
      logic [31:0] fa;
      logic        x_ready;
      logic        x_gnt;
      logic [31:0] x_rdata;
      logic        x_stall;
      logic        x_bd;
      logic        x_err;
      logic [5:0]  x_words;
      logic        x_we;
   } vec_t;

   vec_t tbl [12];

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      idle_inputs();

      //          vld la      ld            last rel freq fa      rdy gnt rdata         stl bd err w  we
      tbl[0]  = '{0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  1,  0, 32'h0,        1, 0, 0, 0, 0};
      tbl[1]  = '{1, 32'h0,  32'hffa9a983, 0, 0, 1, 32'h0,  1,  0, 32'h0,        1, 0, 0, 0, 1};
      tbl[2]  = '{1, 32'h4,  32'h01498933, 1, 1, 0, 32'h0,  1,  0, 32'h0,        1, 0, 0, 1, 1};
      tbl[3]  = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h4,  0,  1, 32'h01498933, 0, 1, 0, 2, 0};
      tbl[4]  = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h0,  0,  1, 32'hffa9a983, 0, 1, 0, 2, 0};
      tbl[5]  = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h80, 0,  1, 32'h0,        0, 1, 0, 2, 0};
      tbl[6]  = '{0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  RT, 0, 32'h0,        0, 1, 1, 2, 0};
      tbl[7]  = '{0, 32'h0,  32'h0,        0, 1, 0, 32'h0,  RT, 0, 32'h0,        0, 1, 1, 2, 0};
      tbl[8]  = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h4,  1,  0, 32'h0,        1, 0, 1, 0, 0};
      tbl[9]  = '{1, 32'h8,  32'h12345678, 1, 0, 0, 32'h0,  1,  0, 32'h0,        1, 0, 1, 0, 1};
      tbl[10] = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h8,  0,  1, 32'h12345678, 0, 1, 1, 1, 0};
      tbl[11] = '{0, 32'h0,  32'h0,        0, 0, 1, 32'h4,  0,  1, 32'h01498933, 0, 1, 1, 1, 0};

      do_reset();

      // Directed table: boot image, fetch, bad fetch, reload, reboot.
      for (int i = 0; i < 12; i++) begin
         ld_valid = tbl[i].vld; ld_addr = tbl[i].la; ld_data = tbl[i].ld; ld_last = tbl[i].last;
         reload = tbl[i].rel; fetch_req = tbl[i].freq; fetch_addr = tbl[i].fa;
         #1;
         check($sformatf("tbl%0d ld_ready", i), 64'(ld_ready), 64'(tbl[i].x_ready));
         check($sformatf("tbl%0d fetch_gnt", i), 64'(fetch_gnt), 64'(tbl[i].x_gnt));
         check($sformatf("tbl%0d fetch_rdata", i), 64'(fetch_rdata), 64'(tbl[i].x_rdata));
         check($sformatf("tbl%0d cpu_stall", i), 64'(cpu_stall), 64'(tbl[i].x_stall));
         check($sformatf("tbl%0d boot_done", i), 64'(boot_done), 64'(tbl[i].x_bd));
         check($sformatf("tbl%0d err", i), 64'(err), 64'(tbl[i].x_err));
         check($sformatf("tbl%0d words_loaded", i), 64'(words_loaded), 64'(tbl[i].x_words));
         check($sformatf("tbl%0d mem_we", i), 64'(mem_we), 64'(tbl[i].x_we));
         cycle();
      end

      // Loader and fetch contend continuously in RUN.
      ld_valid = 1; ld_addr = 32'hC; ld_data = 32'hcafef00d; fetch_req = 1; fetch_addr = 32'h8;
      for (int k = 0; k < 6; k++) begin
         #1;
`ifdef IMEM_ARB_RUNTIME_LOAD_EN
         check($sformatf("fair%0d fetch_gnt", k), 64'(fetch_gnt), 64'(k != 4));
         check($sformatf("fair%0d ld_ready", k), 64'(ld_ready), 64'(k == 4));
         check($sformatf("fair%0d cpu_stall", k), 64'(cpu_stall), 64'(k == 4));
         check($sformatf("fair%0d mem_we", k), 64'(mem_we), 64'(k == 4));
`else
         check($sformatf("fair%0d fetch_gnt", k), 64'(fetch_gnt), 64'h1);
         check($sformatf("fair%0d ld_ready", k), 64'(ld_ready), 64'h0);
`endif
         cycle();
      end
      idle_inputs();
      fetch_req = 1; fetch_addr = 32'hC;
      cycle();
      idle_inputs();

      // Reset in the middle of a boot load after three writes.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1; ld_addr = 32'(k * 4); ld_data = $urandom;
         cycle();
      end
      check("midboot words_loaded", 64'(words_loaded), 64'h3);
      #3;
      do_reset();

      // Bad loader addresses in BOOT: accepted, not written, not counted, err sticky.
      ld_valid = 1; ld_addr = 32'h6; ld_data = 32'hdeadbeef;
      cycle();
      check("bad ld err", 64'(err), 64'h1);
      ld_addr = 32'h80;
      cycle();
      check("bad ld words_loaded", 64'(words_loaded), 64'h0);
      ld_addr = 32'h0; ld_data = 32'h00000013; ld_last = 1;
      cycle();
      idle_inputs();
      fetch_req = 1; fetch_addr = 32'h4;
      cycle();
      idle_inputs();

      // Saturation of the write counter at the memory depth.
      do_reset();
      for (int k = 0; k < 33; k++) begin
         ld_valid = 1; ld_addr = 32'((k % 32) * 4); ld_data = $urandom;
         cycle();
      end
      check("sat words_loaded", 64'(words_loaded), 64'd32);
      ld_last = 1;
      cycle();
      idle_inputs();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         ld_valid   = ($urandom_range(0, 9) < 6);
         ld_addr    = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 31)) << 2;
         ld_data    = $urandom;
         ld_last    = ($urandom_range(0, 9) == 0);
         reload     = ($urandom_range(0, 39) == 0);
         fetch_req  = ($urandom_range(0, 9) < 7);
         fetch_addr = ($urandom_range(0, 29) == 0) ? $urandom : 32'($urandom_range(0, 31)) << 2;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
